timer_counter: RTL and testbench
================================

# timer_counter

Memory-mapped 32-bit down-counting timer that sits on the CPU data bus downstream of the bridge and drives the `interrupt` input of `mips`. The CPU loads a preset, enables the counter, and receives an interrupt when the count expires. It is the device the interrupt test flow relies on to raise timed external interrupts alongside the interrupt generator at 0x7f20.

## Interface
- `BASE`, default 32'h0000_7f00: word-aligned base address; the block decodes a 16-byte window.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `addr` in 32: byte address from the bridge; `addr[1:0]` ignored.
- `we` in 1: write strobe, qualified by `byteen`.
- `byteen` in 4: per-byte write enables; bit i covers `wdata[8i+7:8i]`.
- `wdata` in 32: write data.
- `rdata` out 32: combinational read data for `addr`.
- `irq` out 1: registered interrupt request to the CPU.

## Operation
- Selected when `addr[31:4] == BASE[31:4]`. Offsets by `addr[3:2]`:
  - 0 CTRL: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 10/11 behave as 00), bit3 IM (irq mask). Other bits read 0.
  - 1 PRESET: R/W, 32 bits.
  - 2 COUNT: read-only; writes ignored.
  - 3 reserved: reads 0, writes ignored.
- A write occurs when selected, `we` = 1 and `byteen` != 0. Only enabled bytes change.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT <= PRESET -> CNT.
  - CNT: EN=0 -> IDLE, COUNT held. Else COUNT > 1 -> COUNT-1. Else (COUNT is 0 or 1) COUNT <= 0, FLAG <= 1 -> INT.
  - INT: MODE 00 clears EN, FLAG held, -> IDLE. MODE 01 clears FLAG, -> IDLE, which reloads because EN is still 1.
- `irq` = FLAG & IM, registered.
- In one-shot mode, FLAG clears on any write to CTRL.
- A write to PRESET during CNT does not affect the current run. It is used at the next LOAD.
- A CPU write to CTRL in the same cycle as an FSM update of EN takes priority over the FSM.
- PRESET = 0 behaves exactly like PRESET = 1.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, FLAG = 0, state IDLE, `irq` = 0, `rdata` = 0 for any address.
- Writes take effect at the rising edge where `we` is sampled. `rdata` reflects register contents in the same cycle, before that edge's update.
- EN written at edge T with PRESET = N (N >= 1):
  - LOAD at T+1.
  - COUNT = N at T+2.
  - COUNT = 0 and FLAG = 1 at T+N+2.
  - `irq` is high from T+N+2 if IM = 1.
- Auto-reload: `irq` is high for exactly 1 cycle per period. The period is N+3 cycles.
- Clearing EN during CNT freezes COUNT at the next edge. Re-enabling restarts from LOAD, not from the frozen value.
- Reset asserted mid-count returns everything to reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `timer_pkg`:
  - state enum (IDLE/LOAD/CNT/INT);
  - offset constants (CTRL=0, PRESET=1, COUNT=2);
  - CTRL bit positions (EN=0, MODE=2:1, IM=3);
  - mode constants.
- Single module with no sub-module. The byte-merge helper is a local function.

## Test plan
- Reset, then read offsets 0/4/8/c -> all return 0. `irq` = 0.
- Write PRESET = 5, then CTRL = 0x9 (EN, one-shot, IM) at edge T -> COUNT reads 5,4,3,2,1 on successive cycles. `irq` rises at T+7 and stays high; CTRL reads 0x8. Writing CTRL = 0x8 drops `irq` after the next edge.
- PRESET = 3, CTRL = 0xB (auto-reload) -> `irq` is a 1-cycle pulse every 6 cycles, 4 pulses observed.
- Mid-count, write CTRL = 0x8 -> COUNT freezes and `irq` stays 0. Rewrite 0x9 -> COUNT reloads PRESET 2 cycles later.
- `byteen` = 4'b0001 write of 0xFFFF_FF00 to PRESET = 0x1234_5678 -> PRESET = 0x1234_5600. A write to COUNT leaves it unchanged.
- Assert `reset` asynchronously between clock edges during CNT -> all outputs 0 before the next edge. FSM in IDLE after release.

Source files
------------

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the memory-mapped down-counting timer:
//   - FSM state encoding (IDLE/LOAD/CNT/INT)
//   - register offsets within the 16-byte window (addr[3:2])
//   - CTRL bit positions and MODE encodings
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Word offsets, compared against addr[3:2]
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    // MODE encodings; 2'b10 and 2'b11 behave as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_AUTO    = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
// 32-bit down-counting timer on the CPU data bus. The CPU loads PRESET,
// sets CTRL.EN, and receives irq when the count expires (one-shot or
// auto-reload).
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high, clears all state
//   addr[31:0] in   byte address; window selected when addr[31:4]==BASE[31:4]
//   we         in   write strobe
//   byteen[3:0]in   per-byte write enables
//   wdata[31:0]in   write data
//   rdata[31:0]out  combinational read data for addr (0 when not selected)
//   irq        out  registered interrupt request (FLAG & IM)
//   dbg_state  out  current FSM state (timer_state_e encoding)
//
// Bus protocol: there is no valid/ready handshake. A write is accepted on
// every rising edge where the window is selected, we=1 and byteen!=0; it
// never stalls. Reads are combinational and always available.
// -----------------------------------------------------------------------------
module timer_counter
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_7f00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    output logic [1:0]  dbg_state
);

    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    timer_state_e      state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       preset_q, preset_d;
    logic [31:0]       count_q, count_d;
    logic              flag_q, flag_d;
    logic              irq_q, irq_d;

    logic       sel;
    logic       wr;
    logic       wr_ctrl;
    logic       wr_preset;
    logic       en;
    logic       is_auto;
    logic [1:0] unused_addr;

    assign unused_addr = addr[1:0];

    assign sel       = (addr[31:4] == BASE[31:4]);
    assign wr        = sel && we && (byteen != 4'b0000);
    assign wr_ctrl   = wr && (addr[3:2] == OFF_CTRL);
    assign wr_preset = wr && (addr[3:2] == OFF_PRESET);
    assign en        = ctrl_q[CTRL_EN];
    assign is_auto   = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);

    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        // One-shot FLAG is acknowledged by any CTRL write; an expiry in the
        // same cycle (below) still sets it so the interrupt is not lost.
        flag_d   = (wr_ctrl && !is_auto) ? 1'b0 : flag_q;

        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // COUNT of 0 or 1 both expire, so PRESET=0 acts like 1
                    count_d = 32'd0;
                    flag_d  = 1'b1;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                if (is_auto) flag_d = 1'b0;
                else         ctrl_d[CTRL_EN] = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU writes to CTRL override the FSM's own update of EN
        if (wr_ctrl && byteen[0]) ctrl_d = wdata[CTRL_W-1:0];
        if (wr_preset) preset_d = byte_merge(preset_q, wdata, byteen);

        // irq follows the next-state FLAG/IM so it rises on the expiry edge
        irq_d = flag_d & ctrl_d[CTRL_IM];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (addr[3:2])
                OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
                OFF_PRESET: rdata = preset_q;
                OFF_COUNT:  rdata = count_q;
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign irq       = irq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;
    import timer_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_7f00;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    timer_counter #(.BASE(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .we        (we),
        .byteen    (byteen),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_addr(input logic [1:0] off);
        return BASE | {28'd0, off, 2'b00};
    endfunction

    // Write is sampled at the next rising edge; returns 1ns after it
    task automatic bus_write(input logic [31:0] a, input logic [31:0] data, input logic [3:0] be);
        addr   = a;
        wdata  = data;
        byteen = be;
        we     = 1'b1;
        tick();
        we     = 1'b0;
        byteen = 4'b0000;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        #1;
        d = rdata;
    endtask

    // Bring the timer to IDLE with FLAG cleared (second write lands in one-shot mode)
    task automatic idle_timer();
        bus_write(reg_addr(OFF_CTRL), 32'd0, 4'hF);
        repeat (3) tick();
        bus_write(reg_addr(OFF_CTRL), 32'd0, 4'hF);
    endtask

    // Reference model: with EN written at edge T and PRESET=n (neff = max(n,1)),
    // k cycles later COUNT is n at k=2, then neff-(k-2) down to 0; FLAG sets at
    // k=neff+2. Auto-reload repeats with period neff+3.
    task automatic run_trial(input int n, input logic [1:0] mode, input logic im, input int periods);
        int          neff;
        int          p;
        int          len;
        int          j;
        int          pulses;
        logic        is_auto;
        logic        exp_irq;
        logic [31:0] d;
        logic [31:0] e;
        neff    = (n == 0) ? 1 : n;
        p       = neff + 3;
        is_auto = (mode == 2'b01);
        len     = is_auto ? (2 + periods * p) : (neff + 5);
        idle_timer();
        bus_write(reg_addr(OFF_PRESET), n, 4'hF);
        exp_q.delete();
        for (int k = 2; k <= len; k++) begin
            j = is_auto ? ((k - 2) % p) : (k - 2);
            if (j == 0)        e = n;
            else if (neff > j) e = neff - j;
            else               e = 32'd0;
            exp_q.push_back(e);
        end
        bus_write(reg_addr(OFF_CTRL), {28'd0, im, mode, 1'b1}, 4'h1);
        pulses = 0;
        for (int k = 1; k <= len; k++) begin
            tick();
            bus_read(reg_addr(OFF_COUNT), d);
            if (k >= 2) check($sformatf("count n=%0d m=%0d k=%0d", n, mode, k), d, exp_q.pop_front());
            if (is_auto) exp_irq = im && (k >= 2) && (((k - 2) % p) == neff);
            else         exp_irq = im && (k >= neff + 2);
            if (irq) pulses++;
            check($sformatf("irq n=%0d m=%0d k=%0d", n, mode, k), irq, exp_irq);
        end
        bus_read(reg_addr(OFF_CTRL), d);
        if (is_auto) begin
            check("auto ctrl", d, {28'd0, im, mode, 1'b1});
            check("auto pulses", pulses, im ? periods : 0);
        end else begin
            check("oneshot ctrl en cleared", d, {28'd0, im, mode, 1'b0});
            bus_write(reg_addr(OFF_CTRL), {28'd0, im, mode, 1'b0}, 4'hF);
            check("oneshot irq ack", irq, 1'b0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [31:0] model_preset;
        logic [31:0] rnd;
        logic [3:0]  be;

        reset  = 1'b1;
        we     = 1'b0;
        addr   = 32'd0;
        wdata  = 32'd0;
        byteen = 4'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        for (int i = 0; i < 4; i++) begin
            bus_read(reg_addr(i[1:0]), d);
            check($sformatf("reset rd off%0d", i), d, 32'd0);
        end
        check("reset irq", irq, 1'b0);
        check("reset state", dbg_state, ST_IDLE);
        tick();

        // Byte enables, read-only COUNT, reserved, out-of-window
        bus_write(reg_addr(OFF_PRESET), 32'h1234_5678, 4'hF);
        bus_write(reg_addr(OFF_PRESET), 32'hFFFF_FF00, 4'b0001);
        bus_read(reg_addr(OFF_PRESET), d);
        check("preset byte0", d, 32'h1234_5600);
        model_preset = 32'h1234_5600;
        bus_write(reg_addr(OFF_COUNT), 32'hDEAD_BEEF, 4'hF);
        bus_read(reg_addr(OFF_COUNT), d);
        check("count ro", d, 32'd0);
        bus_write(reg_addr(2'd3), 32'hCAFE_F00D, 4'hF);
        bus_read(reg_addr(2'd3), d);
        check("reserved", d, 32'd0);
        bus_write(BASE + 32'h14, 32'hAAAA_AAAA, 4'hF);
        bus_read(reg_addr(OFF_PRESET), d);
        check("out of window write", d, model_preset);
        bus_read(BASE + 32'h14, d);
        check("out of window read", d, 32'd0);
        for (int i = 0; i < 6; i++) begin
            rnd = $urandom;
            be  = 4'($urandom_range(0, 15));
            bus_write(reg_addr(OFF_PRESET), rnd, be);
            for (int b = 0; b < 4; b++)
                if (be[b]) model_preset[8*b +: 8] = rnd[8*b +: 8];
            bus_read(reg_addr(OFF_PRESET), d);
            check($sformatf("preset rnd be=%h", be), d, model_preset);
        end

        // Directed: one-shot N=5 with IM, auto-reload N=3 four pulses
        run_trial(5, 2'b00, 1'b1, 1);
        run_trial(3, 2'b01, 1'b1, 4);
        run_trial(0, 2'b00, 1'b1, 1);

        // Freeze and restart
        idle_timer();
        bus_write(reg_addr(OFF_PRESET), 32'd20, 4'hF);
        bus_write(reg_addr(OFF_CTRL), 32'h9, 4'hF);
        repeat (5) tick();
        bus_write(reg_addr(OFF_CTRL), 32'h8, 4'hF);
        bus_read(reg_addr(OFF_COUNT), d);
        check("freeze edge", d, 32'd16);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus_read(reg_addr(OFF_COUNT), d);
            check($sformatf("frozen %0d", i), d, 32'd16);
            check($sformatf("frozen irq %0d", i), irq, 1'b0);
        end
        bus_write(reg_addr(OFF_CTRL), 32'h9, 4'hF);
        bus_read(reg_addr(OFF_COUNT), d);
        check("restart +0", d, 32'd16);
        tick();
        bus_read(reg_addr(OFF_COUNT), d);
        check("restart +1", d, 32'd16);
        tick();
        bus_read(reg_addr(OFF_COUNT), d);
        check("restart +2 reload", d, 32'd20);

        // Randomized trials
        for (int t = 0; t < 16; t++) begin
            run_trial(int'($urandom_range(0, 9)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), int'($urandom_range(2, 3)));
        end

        // Asynchronous reset mid-count
        idle_timer();
        bus_write(reg_addr(OFF_PRESET), 32'd50, 4'hF);
        bus_write(reg_addr(OFF_CTRL), 32'h9, 4'hF);
        repeat (4) tick();
        bus_read(reg_addr(OFF_COUNT), d);
        check("pre-reset count", d, 32'd48);
        #1 reset = 1'b1;
        #1;
        check("async rst count", rdata, 32'd0);
        check("async rst irq", irq, 1'b0);
        check("async rst state", dbg_state, ST_IDLE);
        bus_read(reg_addr(OFF_CTRL), d);
        check("async rst ctrl", d, 32'd0);
        bus_read(reg_addr(OFF_PRESET), d);
        check("async rst preset", d, 32'd0);
        #1 reset = 1'b0;
        tick();
        check("post-reset state", dbg_state, ST_IDLE);
        tick();
        check("post-reset state 2", dbg_state, ST_IDLE);
        bus_read(reg_addr(OFF_COUNT), d);
        check("post-reset count", d, 32'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
